// File: rtl/alu.sv
// 8-bit two's-complement ALU with a registered {Z,N,C,V} flag set; no flow control, always ready.
// result/flags_next are combinational (0 cycles); flags load 1 cycle later when flags_we is set.
module alu #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [2:0]       opcode,
  input  logic [WIDTH-1:0] operand_a,
  input  logic [WIDTH-1:0] operand_b,
  input  logic             flags_we,
  output logic [WIDTH-1:0] result,
  output logic [3:0]       flags_next,
  output logic [3:0]       flags
);

  typedef struct packed {
    logic z;
    logic n;
    logic c;
    logic v;
  } flags_t;

  localparam logic [2:0] OP_AND  = 3'b000;
  localparam logic [2:0] OP_OR   = 3'b001;
  localparam logic [2:0] OP_NAND = 3'b010;
  localparam logic [2:0] OP_NOR  = 3'b011;
  localparam logic [2:0] OP_ADD  = 3'b100;
  localparam logic [2:0] OP_SUB  = 3'b101;
  localparam logic [2:0] OP_XOR  = 3'b110;
  localparam logic [2:0] OP_PASS = 3'b111;

  logic             is_sub;
  logic             is_arith;
  logic [WIDTH-1:0] addend_b;
  logic [WIDTH:0]   sum_ext;
  logic [WIDTH-1:0] res;
  flags_t           flg_nxt;
  flags_t           flg_q;

  assign is_sub   = (opcode == OP_SUB);
  assign is_arith = (opcode == OP_ADD) || is_sub;

  // Subtraction shares the adder: A + ~B + 1, so carry-out reads as "no borrow".
  assign addend_b = is_sub ? ~operand_b : operand_b;
  assign sum_ext  = {1'b0, operand_a} + {1'b0, addend_b} + {{WIDTH{1'b0}}, is_sub};

  always_comb begin
    res = operand_a;
    case (opcode)
      OP_AND:  res = operand_a & operand_b;
      OP_OR:   res = operand_a | operand_b;
      OP_NAND: res = ~(operand_a & operand_b);
      OP_NOR:  res = ~(operand_a | operand_b);
      OP_ADD:  res = sum_ext[WIDTH-1:0];
      OP_SUB:  res = sum_ext[WIDTH-1:0];
      OP_XOR:  res = operand_a ^ operand_b;
      OP_PASS: res = operand_a;
      default: res = operand_a;
    endcase
  end

  // Overflow: operands entering the adder agree in sign but the sum does not.
  always_comb begin
    flg_nxt   = '0;
    flg_nxt.z = (res == '0);
    flg_nxt.n = res[WIDTH-1];
    if (is_arith) begin
      flg_nxt.c = sum_ext[WIDTH];
      flg_nxt.v = (operand_a[WIDTH-1] == addend_b[WIDTH-1]) &&
                  (res[WIDTH-1] != operand_a[WIDTH-1]);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      flg_q <= '0;
    end else if (flags_we) begin
      flg_q <= flg_nxt;
    end
  end

  assign result     = res;
  assign flags_next = flg_nxt;
  assign flags      = flg_q;

endmodule

// File: tb/tb_alu.sv
// Directed-vector bench for alu: hand-computed results and {Z,N,C,V} flags, plus flag-register control.
module tb_alu;

  logic       clk;
  logic       rst_n;
  logic [2:0] opcode;
  logic [7:0] operand_a;
  logic [7:0] operand_b;
  logic       flags_we;
  logic [7:0] result;
  logic [3:0] flags_next;
  logic [3:0] flags;

  int vec_cnt = 0;
  int err_cnt = 0;

  typedef struct {
    logic [2:0] op;
    logic [7:0] a;
    logic [7:0] b;
    logic [7:0] r;
    logic [3:0] f;
  } vec_t;

  vec_t vecs[$];

  alu #(.WIDTH(8)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .opcode     (opcode),
    .operand_a  (operand_a),
    .operand_b  (operand_b),
    .flags_we   (flags_we),
    .result     (result),
    .flags_next (flags_next),
    .flags      (flags)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
    vec_cnt++;
    if (got !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic add_vec(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b,
                         input logic [7:0] r, input logic [3:0] f);
    vec_t v;
    v.op = op; v.a = a; v.b = b; v.r = r; v.f = f;
    vecs.push_back(v);
  endtask

  task automatic drive(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b);
    opcode = op; operand_a = a; operand_b = b;
  endtask

  initial begin
    // Logic sweep, A = 0x0F / 0x00 / 0xFF against B = 0x55
    add_vec(3'b000, 8'h0F, 8'h55, 8'h05, 4'b0000);
    add_vec(3'b001, 8'h0F, 8'h55, 8'h5F, 4'b0000);
    add_vec(3'b010, 8'h0F, 8'h55, 8'hFA, 4'b0100);
    add_vec(3'b011, 8'h0F, 8'h55, 8'hA0, 4'b0100);
    add_vec(3'b110, 8'h0F, 8'h55, 8'h5A, 4'b0000);
    add_vec(3'b111, 8'h0F, 8'h55, 8'h0F, 4'b0000);
    add_vec(3'b000, 8'h00, 8'h55, 8'h00, 4'b1000);
    add_vec(3'b001, 8'h00, 8'h55, 8'h55, 4'b0000);
    add_vec(3'b010, 8'h00, 8'h55, 8'hFF, 4'b0100);
    add_vec(3'b011, 8'h00, 8'h55, 8'hAA, 4'b0100);
    add_vec(3'b000, 8'hFF, 8'h55, 8'h55, 4'b0000);
    add_vec(3'b001, 8'hFF, 8'h55, 8'hFF, 4'b0100);
    add_vec(3'b010, 8'hFF, 8'h55, 8'hAA, 4'b0100);
    add_vec(3'b011, 8'hFF, 8'h55, 8'h00, 4'b1000);
    add_vec(3'b110, 8'hFF, 8'h55, 8'hAA, 4'b0100);
    add_vec(3'b111, 8'h80, 8'h55, 8'h80, 4'b0100);
    // ADD
    add_vec(3'b100, 8'h00, 8'h55, 8'h55, 4'b0000);
    add_vec(3'b100, 8'hFF, 8'h55, 8'h54, 4'b0010);
    add_vec(3'b100, 8'h0F, 8'h55, 8'h64, 4'b0000);
    add_vec(3'b100, 8'h7F, 8'h01, 8'h80, 4'b0101);
    add_vec(3'b100, 8'hFF, 8'h01, 8'h00, 4'b1010);
    add_vec(3'b100, 8'h80, 8'h80, 8'h00, 4'b1011);
    // SUB
    add_vec(3'b101, 8'h00, 8'h55, 8'hAB, 4'b0100);
    add_vec(3'b101, 8'hFF, 8'h55, 8'hAA, 4'b0110);
    add_vec(3'b101, 8'h0F, 8'h55, 8'hBA, 4'b0100);
    add_vec(3'b101, 8'h55, 8'h55, 8'h00, 4'b1010);
    add_vec(3'b101, 8'h80, 8'h01, 8'h7F, 4'b0011);
    add_vec(3'b101, 8'h7F, 8'hFF, 8'h80, 4'b0101);

    // Reset asserted from time zero: outputs valid with no clock edge yet
    rst_n = 1'b0; flags_we = 1'b0;
    drive(3'b000, 8'h00, 8'h00);
    #1;
    chk("rst result", result, 8'h00);
    chk("rst flags", {4'h0, flags}, 8'h00);

    // flags_we ignored while in reset, even across an edge
    drive(3'b100, 8'hFF, 8'h01);
    flags_we = 1'b1;
    @(posedge clk); #1;
    chk("rst we ignored", {4'h0, flags}, 8'h00);
    @(negedge clk);
    flags_we = 1'b0;
    rst_n = 1'b1;

    // Combinational sweep with no flag load; registered flags must stay put
    foreach (vecs[i]) begin
      @(negedge clk);
      drive(vecs[i].op, vecs[i].a, vecs[i].b);
      #1;
      chk($sformatf("v%0d result", i), result, vecs[i].r);
      chk($sformatf("v%0d flags_next", i), {4'h0, flags_next}, {4'h0, vecs[i].f});
      chk($sformatf("v%0d flags hold", i), {4'h0, flags}, 8'h00);
    end

    // Same-cycle response between edges
    @(posedge clk); #2;
    drive(3'b101, 8'h55, 8'h55);
    #1;
    chk("comb result a", result, 8'h00);
    chk("comb flags_next a", {4'h0, flags_next}, 8'h0A);
    drive(3'b110, 8'h0F, 8'hF0);
    #1;
    chk("comb result b", result, 8'hFF);
    chk("comb flags_next b", {4'h0, flags_next}, 8'h04);
    chk("comb flags hold", {4'h0, flags}, 8'h00);

    // Load ZC from 0xFF + 0x01
    @(negedge clk);
    drive(3'b100, 8'hFF, 8'h01);
    flags_we = 1'b1;
    @(posedge clk); #1;
    chk("load zc", {4'h0, flags}, 8'h0A);

    // Hold with flags_we low while operands change
    @(negedge clk);
    flags_we = 1'b0;
    drive(3'b100, 8'h0F, 8'h55);
    @(posedge clk); #1;
    chk("hold flags", {4'h0, flags}, 8'h0A);
    chk("hold flags_next", {4'h0, flags_next}, 8'h00);

    // Load CV from 0x80 - 0x01
    @(negedge clk);
    drive(3'b101, 8'h80, 8'h01);
    flags_we = 1'b1;
    @(posedge clk); #1;
    chk("load cv", {4'h0, flags}, 8'h03);

    // Asynchronous reset pulse between edges
    #2;
    rst_n = 1'b0;
    #1;
    chk("async rst flags", {4'h0, flags}, 8'h00);
    chk("async rst result", result, 8'h7F);
    rst_n = 1'b1;
    flags_we = 1'b0;
    @(posedge clk); #1;
    chk("post rst hold", {4'h0, flags}, 8'h00);

    // Reload after reset
    @(negedge clk);
    drive(3'b111, 8'h80, 8'h00);
    flags_we = 1'b1;
    @(posedge clk); #1;
    chk("reload n", {4'h0, flags}, 8'h04);

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule
